// File: rtl/sqrt_reconstruct_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sqrt_pkg
// Description : Shared types and width helpers for the square-root unit and
//               its reconstruction (Q*Q + R) companion.
// Revision    : 1.0 - initial release
// ============================================================================
package sqrt_pkg;

    // Reconstruction FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        ADD  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Remainder of an N-bit root needs one extra bit (R <= 2Q)
    function automatic int rem_width(input int root_width);
        return root_width + 1;
    endfunction

    // Radicand width plus one guard bit so an illegal R cannot overflow
    function automatic int data_width(input int root_width);
        return 2 * root_width + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sqrt_reconstruct_if.sv
`default_nettype none
// ============================================================================
// Module      : sqrt_reconstruct_if
// Description : Valid/ready request and result channels of sqrt_reconstruct.
// Revision    : 1.0 - initial release
// ============================================================================
interface sqrt_reconstruct_if
    import sqrt_pkg::*;
#(
    parameter int ROOT_WIDTH = 4
);
    localparam int REM_WIDTH  = rem_width(ROOT_WIDTH);
    localparam int DATA_WIDTH = data_width(ROOT_WIDTH);

    logic                  in_valid;
    logic                  in_ready;
    logic [ROOT_WIDTH-1:0] q_in;
    logic [REM_WIDTH-1:0]  r_in;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] d_out;
    logic                  rem_err;

    // Requester / result consumer side
    modport master (
        output in_valid, q_in, r_in, out_ready,
        input  in_ready, out_valid, d_out, rem_err
    );

    // Reconstruction block side
    modport slave (
        input  in_valid, q_in, r_in, out_ready,
        output in_ready, out_valid, d_out, rem_err
    );
endinterface
`default_nettype wire

// File: rtl/sqrt_reconstruct.sv
`default_nettype none
// ============================================================================
// Module      : sqrt_reconstruct
// Description : Rebuilds D = Q*Q + R from a root/remainder pair with an
//               LSB-first shift-add squarer, and flags R > 2Q as invalid.
// Revision    : 1.0 - initial release
// ============================================================================
module sqrt_reconstruct
    import sqrt_pkg::*;
#(
    parameter int ROOT_WIDTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    sqrt_reconstruct_if.slave bus
);
    localparam int REM_WIDTH  = rem_width(ROOT_WIDTH);
    localparam int DATA_WIDTH = data_width(ROOT_WIDTH);
    localparam int CNT_WIDTH  = (ROOT_WIDTH > 1) ? $clog2(ROOT_WIDTH) : 1;
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(ROOT_WIDTH - 1);

    state_t                state;
    state_t                state_nx;
    logic                  accept;
    logic [ROOT_WIDTH-1:0] q_reg;
    logic [REM_WIDTH-1:0]  r_reg;
    logic [DATA_WIDTH-1:0] mcand;
    logic [DATA_WIDTH-1:0] acc;
    logic [DATA_WIDTH-1:0] d_reg;
    logic [CNT_WIDTH-1:0]  cnt;
    logic                  rem_err_nx;
    logic                  rem_err_reg;
    logic                  out_valid_reg;

    // in_ready depends on the state register only, never on an input
    assign bus.in_ready  = (state == IDLE);
    assign accept        = bus.in_valid && (state == IDLE);
    assign bus.out_valid = out_valid_reg;
    assign bus.d_out     = d_reg;
    assign bus.rem_err   = rem_err_reg;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic: fixed N multiply steps regardless of operand values
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = MUL;
            MUL:     if (cnt == CNT_LAST) state_nx = ADD;
            ADD:     state_nx = DONE;
            DONE:    if (bus.out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Squarer datapath and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_reg         <= '0;
            r_reg         <= '0;
            mcand         <= '0;
            acc           <= '0;
            cnt           <= '0;
            rem_err_nx    <= 1'b0;
            rem_err_reg   <= 1'b0;
            d_reg         <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        q_reg      <= bus.q_in;
                        r_reg      <= bus.r_in;
                        mcand      <= DATA_WIDTH'(bus.q_in);
                        acc        <= '0;
                        cnt        <= '0;
                        rem_err_nx <= (bus.r_in > {bus.q_in, 1'b0});
                    end
                end
                MUL: begin
                    if (q_reg[0]) begin
                        acc <= acc + mcand;
                    end
                    mcand <= mcand << 1;
                    q_reg <= q_reg >> 1;
                    cnt   <= cnt + 1'b1;
                end
                ADD: begin
                    // Guard bit absorbs the carry of an illegal R
                    d_reg         <= acc + DATA_WIDTH'(r_reg);
                    rem_err_reg   <= rem_err_nx;
                    out_valid_reg <= 1'b1;
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_reg <= 1'b0;
                    end
                end
                default: begin
                    out_valid_reg <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sqrt_reconstruct.sv
`default_nettype none
// ============================================================================
// Module      : tb_sqrt_reconstruct
// Description : Self-checking bench for sqrt_reconstruct: directed cases,
//               backpressure, mid-operation reset and square-root round trip.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sqrt_reconstruct;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    sqrt_reconstruct_if #(.ROOT_WIDTH(4)) bus ();

    sqrt_reconstruct #(.ROOT_WIDTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // 10-unit clock
    always #5 clk = ~clk;

    // Absolute time bound so the run always ends
    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Issue one request, measure latency, check the result, then consume it
    task automatic run(input int q, input int r, input int exp_d, input int exp_err,
                       input string tag);
        int cyc;
        @(negedge clk);
        check({tag, ":in_ready_before"}, int'(bus.in_ready), 1);
        bus.q_in     = q[3:0];
        bus.r_in     = r[4:0];
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        cyc = 0;
        while (cyc < 20) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (bus.out_valid) break;
        end
        check({tag, ":latency"}, cyc, 5);
        check({tag, ":d_out"}, int'(bus.d_out), exp_d);
        check({tag, ":rem_err"}, int'(bus.rem_err), exp_err);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        check({tag, ":in_ready_after"}, int'(bus.in_ready), 1);
        check({tag, ":out_valid_after"}, int'(bus.out_valid), 0);
    endtask

    initial begin
        int perm[256];
        int tmp;
        int j;
        int q;
        int r;
        int cyc;

        bus.in_valid  = 1'b0;
        bus.q_in      = '0;
        bus.r_in      = '0;
        bus.out_ready = 1'b0;

        // Reset state
        #12;
        check("reset:in_ready", int'(bus.in_ready), 1);
        check("reset:out_valid", int'(bus.out_valid), 0);
        check("reset:d_out", int'(bus.d_out), 0);
        check("reset:rem_err", int'(bus.rem_err), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases
        run(11, 19, 140, 0, "q11r19");
        run(0, 0, 0, 0, "q0r0");
        run(15, 30, 255, 0, "q15r30");
        run(11, 23, 144, 1, "q11r23");
        run(15, 31, 256, 1, "q15r31_guard");

        // Backpressure: result held for 3 clocks, stray request ignored
        @(negedge clk);
        bus.q_in = 4'd5;
        bus.r_in = 5'd3;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        cyc = 0;
        while (cyc < 20) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (bus.out_valid) break;
        end
        check("bp:latency", cyc, 5);
        for (int k = 0; k < 3; k++) begin
            check("bp:out_valid_hold", int'(bus.out_valid), 1);
            check("bp:d_out_hold", int'(bus.d_out), 28);
            check("bp:in_ready_low", int'(bus.in_ready), 0);
            if (k == 1) begin
                bus.q_in = 4'd9;
                bus.r_in = 5'd1;
                bus.in_valid = 1'b1;
            end
            @(posedge clk);
            #1 bus.in_valid = 1'b0;
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        check("bp:in_ready_after", int'(bus.in_ready), 1);
        check("bp:out_valid_after", int'(bus.out_valid), 0);
        repeat (8) @(posedge clk);
        @(negedge clk);
        check("bp:stray_ignored", int'(bus.out_valid), 0);
        check("bp:d_out_kept", int'(bus.d_out), 28);

        // Reset during the second multiply cycle
        @(negedge clk);
        bus.q_in = 4'd11;
        bus.r_in = 5'd19;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst:out_valid", int'(bus.out_valid), 0);
        check("midrst:d_out", int'(bus.d_out), 0);
        check("midrst:in_ready", int'(bus.in_ready), 1);
        check("midrst:rem_err", int'(bus.rem_err), 0);
        @(negedge clk);
        rst_n = 1'b1;
        run(11, 19, 140, 0, "midrst:fresh");

        // Round trip over every 8-bit radicand in random order
        for (int i = 0; i < 256; i++) perm[i] = i;
        for (int i = 255; i > 0; i--) begin
            j = int'($urandom_range(i, 0));
            tmp = perm[i];
            perm[i] = perm[j];
            perm[j] = tmp;
        end
        for (int i = 0; i < 256; i++) begin
            q = 0;
            while ((q + 1) * (q + 1) <= perm[i]) q++;
            r = perm[i] - q * q;
            run(q, r, perm[i], 0, $sformatf("roundtrip_d%0d", perm[i]));
        end

        // Random pairs over the full remainder range, including illegal R
        for (int i = 0; i < 40; i++) begin
            q = int'($urandom_range(15, 0));
            r = int'($urandom_range(31, 0));
            run(q, r, q * q + r, (r > 2 * q) ? 1 : 0,
                $sformatf("rand_q%0d_r%0d", q, r));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
